// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issue/writeback sequencer wrapped around an external combinational ALU.
//   It accepts one 16-bit ALU-class instruction per handshake and decodes it.
//   Operands come from an internal 8x16 register file and are presented to the
//   ALU. The ALU result is captured and then written back to rd.
//   Each instruction takes four states: IDLE -> DECODE -> EXEC -> WB.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   instr, instr_valid/instr_ready instruction handshake (ready only in IDLE)
//   host_we, host_addr, host_wdata host register write, honoured only in IDLE
//   dbg_addr, dbg_data             combinational register-file read port
//   rsdata, rmdata, N              registered ALU operands
//   instr_bit_15, instr_bit_12_11  registered ALU opcode {[15],[12:11]}
//   aluout                         ALU result
//   done, err                      one-cycle WB pulse; err = illegal, no write
//   result                         last captured ALU result
//   zflag                          zero flag of last legal writeback
//
// Build option
//   ALU_SEQ_ZFLAG_EN  defined: zflag register implemented; undefined: zflag = 0

module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        host_we,
    input  logic [2:0]  host_addr,
    input  logic [15:0] host_wdata,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic [15:0] rsdata,
    output logic [15:0] rmdata,
    output logic [15:0] N,
    output logic        instr_bit_15,
    output logic [1:0]  instr_bit_12_11,
    input  logic [15:0] aluout,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic        zflag
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    state_t      state_q;
    logic [15:0] instr_q;
    logic [15:0] regs_q [8];
    logic [15:0] rsdata_q, rmdata_q, n_q, result_q;
    logic        bit15_q, ready_q, done_q, err_q;
    logic [1:0]  op_q;
    logic        illegal;

    // Illegal when [14:13] is nonzero, or for opcodes 101/111 ([15] and [11] both set).
    assign illegal = (instr_q[14:13] != 2'b00) || (instr_q[15] && instr_q[11]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            rsdata_q <= '0;
            rmdata_q <= '0;
            n_q      <= '0;
            bit15_q  <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (host_we) regs_q[host_addr] <= host_wdata;
                    if (instr_valid && ready_q) begin
                        instr_q <= instr;
                        ready_q <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // The read happens one edge after accept, so a host write
                    // made on the accept edge is already visible here.
                    rsdata_q <= regs_q[instr_q[10:8]];
                    rmdata_q <= regs_q[instr_q[7:5]];
                    n_q      <= {8'h00, instr_q[7:0]};
                    bit15_q  <= instr_q[15];
                    op_q     <= instr_q[12:11];
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    // The result is captured even for illegal instructions;
                    // only the writeback is suppressed.
                    result_q <= aluout;
                    done_q   <= 1'b1;
                    err_q    <= illegal;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    if (!illegal) regs_q[instr_q[10:8]] <= result_q;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    logic zflag_q;
    always_ff @(posedge clk) begin
        if (reset)
            zflag_q <= 1'b0;
        else if (state_q == S_WB && !illegal)
            zflag_q <= (result_q == 16'h0000);
    end
    assign zflag = zflag_q;
`else
    assign zflag = 1'b0;
`endif

    assign instr_ready     = ready_q;
    assign dbg_data        = regs_q[dbg_addr];
    assign rsdata          = rsdata_q;
    assign rmdata          = rmdata_q;
    assign N               = n_q;
    assign instr_bit_15    = bit15_q;
    assign instr_bit_12_11 = op_q;
    assign done            = done_q;
    assign err             = err_q;
    assign result          = result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        host_we;
    logic [2:0]  host_addr;
    logic [15:0] host_wdata;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] rsdata, rmdata, N;
    logic        instr_bit_15;
    logic [1:0]  instr_bit_12_11;
    logic [15:0] aluout;
    logic        done, err;
    logic [15:0] result;
    logic        zflag;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .rsdata(rsdata), .rmdata(rmdata), .N(N), .instr_bit_15(instr_bit_15),
        .instr_bit_12_11(instr_bit_12_11), .aluout(aluout), .done(done),
        .err(err), .result(result), .zflag(zflag)
    );

    always #5 clk = ~clk;

    // ALU: shifts are by one bit; undefined opcodes return ~rs.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] n);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a + n;
            3'b010:  return a - b;
            3'b011:  return a - n;
            3'b100:  return a << 1;
            3'b110:  return a >> 1;
            default: return ~a;
        endcase
    endfunction

    always_comb aluout = alu_f({instr_bit_15, instr_bit_12_11}, rsdata, rmdata, N);

    typedef struct { logic [15:0] res; logic err; } exp_t;
    exp_t        sb[$];
    logic [15:0] mdl [8];
    logic        mdl_z;
    int          nchk = 0, nerr = 0, ndone = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] zexp();
`ifdef ALU_SEQ_ZFLAG_EN
        return 16'(mdl_z);
`else
        return 16'h0;
`endif
    endfunction

    // Compute the expected outcome from the model register file and queue it.
    task automatic push_expect(input logic [15:0] ins);
        logic [2:0]  op;
        logic [15:0] r;
        logic        ill;
        exp_t        e;
        op  = {ins[15], ins[12:11]};
        r   = alu_f(op, mdl[ins[10:8]], mdl[ins[7:5]], {8'h00, ins[7:0]});
        ill = (ins[14:13] != 2'b00) || op == 3'b101 || op == 3'b111;
        if (!ill) begin
            mdl[ins[10:8]] = r;
            mdl_z = (r == 16'h0);
        end
        e.res = r;
        e.err = ill;
        sb.push_back(e);
    endtask

    // Scoreboard: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            ndone++;
            if (sb.size() == 0) chk("sb_spurious_done", 16'h1, 16'h0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("err", 16'(err), 16'(e.err));
            end
        end
    end

    task automatic host_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        mdl[a] = d;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    // Issue one instruction, optionally with a host write on the accept edge.
    // A junk host write to r0 is held during DECODE..WB and must be ignored.
    task automatic issue(input logic [15:0] ins, input logic hw,
                         input logic [2:0] ha, input logic [15:0] hd);
        @(negedge clk);
        chk("ready_idle", 16'(instr_ready), 16'h1);
        instr = ins; instr_valid = 1'b1;
        host_we = hw; host_addr = ha; host_wdata = hd;
        if (hw) mdl[ha] = hd;
        push_expect(ins);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        host_we = 1'b1; host_addr = 3'd0; host_wdata = 16'hBEEF;
        chk("ready_busy", 16'(instr_ready), 16'h0);
        chk("done_early", 16'(done), 16'h0);
        @(posedge clk); #1;
        chk("done_early2", 16'(done), 16'h0);
        @(posedge clk); #1;
        chk("done_lat", 16'(done), 16'h1);
        @(posedge clk); #1;
        host_we = 1'b0;
        chk("done_width", 16'(done), 16'h0);
        dbg_addr = ins[10:8];
        #1;
        chk("dbg_rd", dbg_data, mdl[ins[10:8]]);
        chk("zflag", 16'(zflag), zexp());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] b2b [3];
        int          d0;
        b2b[0] = 16'h0F03;  // ADD I r7,#3
        b2b[1] = 16'h07E0;  // ADD R r7,r7 (rd == rm)
        b2b[2] = 16'h9700;  // LSR r7

        reset = 1'b1; instr = '0; instr_valid = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        mdl_z = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 16'(instr_ready), 16'h1);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_result", result, 16'h0);
        chk("rst_rsdata", rsdata, 16'h0);
        chk("rst_N", N, 16'h0);
        chk("rst_zflag", 16'(zflag), 16'h0);
        chk("rst_dbg", dbg_data, 16'h0);

        host_wr(3'd1, 16'h0005);
        host_wr(3'd2, 16'h0003);
        issue(16'h0140, 1'b0, 3'd0, 16'h0);     // ADD R r1,r2 -> 8
        host_wr(3'd3, 16'h0002);
        issue(16'h1B05, 1'b0, 3'd0, 16'h0);     // SUB I r3,#5 -> FFFD
        host_wr(3'd3, 16'h00FD);
        issue(16'h1BFD, 1'b0, 3'd0, 16'h0);     // SUB I r3,#FD -> 0
        host_wr(3'd4, 16'h8001);
        issue(16'h8400, 1'b0, 3'd0, 16'h0);     // LSL -> 0002
        host_wr(3'd4, 16'h8001);
        issue(16'h9400, 1'b0, 3'd0, 16'h0);     // LSR -> 4000
        issue(16'h2000, 1'b0, 3'd0, 16'h0);     // illegal [14:13]
        issue(16'h2120, 1'b0, 3'd0, 16'h0);     // illegal, would change r1
        issue(16'h8800, 1'b0, 3'd0, 16'h0);     // illegal opcode 101
        issue(16'h0140, 1'b1, 3'd2, 16'h0010);  // host write on accept edge

        // instr_valid held high: ready once per 4 cycles, one accept each.
        d0 = ndone;
        @(negedge clk);
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i % 4 == 0) begin
                instr = b2b[i / 4];
                push_expect(b2b[i / 4]);
            end
            chk("b2b_ready", 16'(instr_ready), 16'(i % 4 == 0));
            @(posedge clk);
            if (i < 8) @(negedge clk);
        end
        #1 instr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dbg_addr = 3'd7;
        #1;
        chk("b2b_r7", dbg_data, mdl[7]);
        chk("b2b_ndone", 16'(ndone - d0), 16'd3);

        // Reset during EXEC aborts the instruction.
        d0 = ndone;
        @(negedge clk);
        instr = 16'h0E01; instr_valid = 1'b1;   // ADD I r6,#1
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk);                         // now in EXEC
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        mdl_z = 1'b0;
        chk("abort_ready", 16'(instr_ready), 16'h1);
        chk("abort_done", 16'(done), 16'h0);
        dbg_addr = 3'd6;
        #1;
        chk("abort_r6", dbg_data, 16'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_r6_late", dbg_data, 16'h0);
        chk("abort_no_done", 16'(ndone - d0), 16'd0);
        chk("abort_zflag", 16'(zflag), zexp());

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
